// File: rtl/adc_pkg.sv
// ============================================================================
// Module : adc_pkg
// Brief  : Shared types and constants for the serial ADC front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    DONE     = 3'd3,
    QUIET    = 3'd4
  } adc_state_e;

  localparam int ADC_DATA_WIDTH = 16;
  localparam int AVG_SAMPLES    = 4;
  localparam int AVG_SHIFT      = 2;

endpackage

`default_nettype wire

// File: rtl/adc_serial_reader_sclk_divider.sv
// ============================================================================
// Module : sclk_divider
// Brief  : Half-period tick generator for sclk; also times CS setup/quiet gaps.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sclk_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o,
  output logic rise_tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign tick_o      = run_i && (cnt_q == CW'(CLK_DIV - 1));
  // Phase 0 is the low half of an sclk period, so its end is a rising edge.
  assign rise_tick_o = tick_o && !phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (run_i) begin
      if (tick_o) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_serial_reader.sv
// ============================================================================
// Module : adc_serial_reader
// Brief  : 3-wire MSB-first serial ADC reader; ADC_AVG4_EN averages 4 samples.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = ADC_DATA_WIDTH,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  adc_sdo,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic [DATA_WIDTH-1:0] adc_data,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  adc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  tick, rise_tick, fall_tick;
  logic                  div_run, div_clr;
  logic                  shift_end;
  logic                  last_conv, more_conv;
  logic [DATA_WIDTH-1:0] result;

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .run_i       (div_run),
    .clr_i       (div_clr),
    .tick_o      (tick),
    .rise_tick_o (rise_tick)
  );

  assign fall_tick = tick && !rise_tick;
  assign shift_end = (state_q == SHIFT) && fall_tick && (bit_q == '0);
  assign div_run   = (state_q == CS_SETUP) || (state_q == SHIFT) || (state_q == QUIET);
  // Every state starts its interval timing from a clean counter.
  assign div_clr   = (state_d != state_q);

`ifdef ADC_AVG4_EN
  localparam int SW  = DATA_WIDTH + AVG_SHIFT;
  localparam int CNW = $clog2(AVG_SAMPLES);

  logic [SW-1:0]  sum_q, sum_d, sum_next;
  logic [CNW-1:0] conv_q, conv_d;

  assign sum_next  = sum_q + SW'(shift_q);
  assign result    = DATA_WIDTH'(sum_next >> AVG_SHIFT);
  assign last_conv = (conv_q == CNW'(AVG_SAMPLES - 1));
  assign more_conv = (conv_q != '0);

  always_comb begin
    sum_d  = sum_q;
    conv_d = conv_q;
    if (shift_end && !last_conv) begin
      sum_d  = sum_next;
      conv_d = conv_q + CNW'(1);
    end else if (state_q == DONE) begin
      sum_d  = '0;
      conv_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      conv_q <= '0;
    end else begin
      sum_q  <= sum_d;
      conv_q <= conv_d;
    end
  end
`else
  assign result    = shift_q;
  assign last_conv = 1'b1;
  assign more_conv = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = CS_SETUP;
      end
      CS_SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          bit_d   = BW'(DATA_WIDTH - 1);
        end
      end
      SHIFT: begin
        if (rise_tick) shift_d = {shift_q[DATA_WIDTH-2:0], adc_sdo};
        if (shift_end) begin
          state_d = last_conv ? DONE : QUIET;
        end else if (fall_tick) begin
          bit_d = bit_q - BW'(1);
        end
      end
      DONE: begin
        state_d = QUIET;
      end
      QUIET: begin
        if (tick) state_d = more_conv ? CS_SETUP : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pins are computed from next state so they leave flops directly.
  always_comb begin
    cs_n_d  = !((state_d == CS_SETUP) || (state_d == SHIFT));
    sclk_d  = (state_q == SHIFT) && (state_d == SHIFT) &&
              (rise_tick || (sclk_q && !fall_tick));
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    data_d  = (state_d == DONE) ? result : data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign adc_data   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- Front end that fetches raw 16-bit samples from an external serial ADC: 3-wire, SPI-mode-0-like, MSB first.
- Presents each sample on adc_data, which feeds the adc_data input of TemperatureCalculator, with a one-cycle data_valid strobe.
- Owns chip-select timing, serial-clock generation, bit capture and the start/busy handshake.

Parameters:
- DATA_WIDTH, 16: bits per conversion; must match the TemperatureCalculator adc_data width.
- CLK_DIV, 2: clk cycles per sclk half-period and per CS setup/quiet interval; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- adc_sdo  input  1  serial data from ADC; the ADC changes it on sclk falling edges.
- adc_cs_n  output  1  ADC chip select, active low.
- adc_sclk  output  1  ADC serial clock.
- adc_data  output  DATA_WIDTH  last completed sample; holds its value between conversions.
- data_valid  output  1  one-cycle strobe when adc_data updates.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=0, adc_data=0, data_valid=0, busy=0; FSM goes to IDLE; the shift register and counters clear.
- Reset is asynchronous, so asserting it mid-operation aborts immediately. No partial data reaches adc_data.
- FSM states: IDLE, CS_SETUP, SHIFT, DONE, QUIET.
- IDLE: when start=1 at edge n, go to CS_SETUP. adc_cs_n goes low and busy goes high from edge n+1.
- CS_SETUP: lasts CLK_DIV cycles with adc_sclk=0, then go to SHIFT.
- SHIFT: DATA_WIDTH bit periods of 2*CLK_DIV cycles each.
  - First CLK_DIV cycles of a period: adc_sclk=0. Last CLK_DIV cycles: adc_sclk=1.
  - On the clk edge where adc_sclk goes 0 to 1, adc_sdo is shifted into the LSB of the shift register (MSB received first).
  - A bit counter runs from DATA_WIDTH-1 down to 0. When the final period ends, go to DONE.
- DONE: 1 cycle. adc_data takes the shift register value, data_valid=1, adc_cs_n=1, adc_sclk=0.
- QUIET: CLK_DIV cycles with adc_cs_n=1 (minimum CS-high time), then go to IDLE.
- Latency: data_valid is high in the cycle after edge n+1+CLK_DIV*(1+2*DATA_WIDTH). With defaults that is edge n+67.
- start while busy=1 is ignored, with no queueing. If start is held high continuously, a new conversion begins the cycle after QUIET ends.
- adc_sclk and adc_cs_n are registered outputs and glitch-free.
- adc_sclk is 0 whenever adc_cs_n=1.

Optional Feature:
- Macro: ADC_AVG4_EN.
- Defined: one accepted start runs 4 full conversions, each CS_SETUP to SHIFT to QUIET. There is no DONE strobe between them.
  - Samples accumulate in a (DATA_WIDTH+2)-bit unsigned sum.
  - After the 4th SHIFT, DONE loads adc_data with sum>>2 (truncated) and pulses data_valid once.
  - busy stays high throughout.
  - Total latency is 4 times the single-conversion latency plus 3*CLK_DIV for the intermediate QUIET intervals.
- Undefined: single conversion as described above; no accumulator logic.

Decomposition:
- Package adc_pkg holds:
  - state enum (IDLE, CS_SETUP, SHIFT, DONE, QUIET);
  - ADC_DATA_WIDTH=16;
  - AVG_SAMPLES=4 and AVG_SHIFT=2.
- Sub-module sclk_divider: takes CLK_DIV, a run enable and clk/reset.
  - Outputs a half-period tick and a rise_tick for sampling.
  - Also reused for the CS_SETUP and QUIET interval counting.

Test Plan (CLK_DIV=2, bench ADC model drives adc_sdo on sclk falling edges and when cs_n falls):
- Model word 16'h4001, start pulse at edge n: adc_data=16'h4001 and one-cycle data_valid at n+67; exactly 16 sclk rising edges seen while adc_cs_n=0.
- Model words 16'hFFFF then 16'h0000 on consecutive starts: adc_data=16'hFFFF then 16'h0000; adc_data holds between conversions.
- Start pulses at n+10 and n+40 during a conversion: ignored; exactly one data_valid; adc_cs_n shows a single low window.
- Reset asserted after the 5th sclk rise: adc_cs_n=1, adc_sclk=0, busy=0, adc_data=0 immediately; a subsequent start with 16'h8001 returns 16'h8001.
- start held high, words 16'h1234 then 16'hABCD: two data_valid pulses; adc_cs_n high for at least CLK_DIV+1 cycles between windows.
- ADC_AVG4_EN with words 16'h7FFF, 16'h8001, 16'h0004, 16'h0000: a single data_valid with adc_data=16'h4001; busy continuous.
